// File: rtl/countdown_timer_core_pkg.sv
// Shared constants and helpers for the countdown timer.
// Contents: FSM state codes, field codes, counter widths and limits,
//           field-value and field-select step helpers.
package countdown_timer_core_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned FIELD_W = 2;
   localparam int unsigned MS_W    = 10;
   localparam int unsigned SEC_W   = 6;
   localparam int unsigned MIN_W   = 6;

   // FSM state encoding (visible on o_state)
   localparam logic [STATE_W-1:0] ST_INIT   = 3'd0;
   localparam logic [STATE_W-1:0] ST_FINISH = 3'd1;
   localparam logic [STATE_W-1:0] ST_PAUSE  = 3'd2;
   localparam logic [STATE_W-1:0] ST_RUN    = 3'd3;
   localparam logic [STATE_W-1:0] ST_SET    = 3'd4;

   // Field under edit in SET
   localparam logic [FIELD_W-1:0] FLD_SEC = 2'd0;
   localparam logic [FIELD_W-1:0] FLD_MIN = 2'd1;
   localparam logic [FIELD_W-1:0] FLD_HR  = 2'd2;

   localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   // Wrapping +/-1 on a 6-bit sec/min field
   function automatic logic [5:0] wrap_step6(input logic [5:0] v,
                                             input logic [5:0] max_v,
                                             input logic       up);
      logic [5:0] r;
      if (up) r = (v >= max_v) ? 6'd0 : v + 6'd1;
      else    r = (v == 6'd0) ? max_v : v - 6'd1;
      return r;
   endfunction

   // Field rotation: right = sec->min->hr->sec, left = reverse
   function automatic logic [FIELD_W-1:0] field_step(input logic [FIELD_W-1:0] f,
                                                     input logic               right);
      logic [FIELD_W-1:0] r;
      case (f)
         FLD_SEC: r = right ? FLD_MIN : FLD_HR;
         FLD_MIN: r = right ? FLD_HR  : FLD_SEC;
         FLD_HR:  r = right ? FLD_SEC : FLD_MIN;
         default: r = FLD_SEC;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/countdown_timer_core_if.sv
// Button/display bundle between the debouncers, the timer core and the display mux.
// i_set/i_up/i_down/i_left/i_right : 1-cycle button pulses into the core
// o_ms/o_sec/o_min/o_hr             : remaining time
// o_state/o_field                   : FSM state code, field under edit
// o_done/o_alarm                    : expiry pulse, alarm level
// slave modport = timer core, master modport = button/display side.
interface countdown_timer_core_if #(
   parameter int unsigned HR_W = 5
);
   import countdown_timer_core_pkg::*;

   logic               i_set;
   logic               i_up;
   logic               i_down;
   logic               i_left;
   logic               i_right;
   logic [MS_W-1:0]    o_ms;
   logic [SEC_W-1:0]   o_sec;
   logic [MIN_W-1:0]   o_min;
   logic [HR_W-1:0]    o_hr;
   logic [STATE_W-1:0] o_state;
   logic [FIELD_W-1:0] o_field;
   logic               o_done;
   logic               o_alarm;

   modport master (
      output i_set, i_up, i_down, i_left, i_right,
      input  o_ms, o_sec, o_min, o_hr, o_state, o_field, o_done, o_alarm
   );

   modport slave (
      input  i_set, i_up, i_down, i_left, i_right,
      output o_ms, o_sec, o_min, o_hr, o_state, o_field, o_done, o_alarm
   );

endinterface

// File: rtl/countdown_timer_core_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler.
// Counts 0..CLK_PER_MS-1 while i_en, holds otherwise, i_clr forces 0.
// o_tick is high during the enabled terminal-count cycle.
// Ports: i_clk, i_rstn (async active-low), i_en, i_clr, o_tick.
module ms_tick_gen #(
   parameter int unsigned CLK_PER_MS = 1000
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_MS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   // Terminal-count strobe
   assign o_tick = i_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/countdown_timer_core.sv
// countdown_timer_core: countdown timer with ms/sec/min/hr counters, preset,
// ms prescaler and control FSM (INIT, SET, PAUSE, RUN, FINISH).
// Ports: i_clk, i_rstn (async active-low), bus (countdown_timer_core_if.slave):
//   buttons in, remaining time / state / field / done / alarm out.
// Build option: TIMER_AUTORELOAD_EN -- on expiry reload the preset and keep
//   running instead of stopping in FINISH; o_alarm stays 0.
module countdown_timer_core
   import countdown_timer_core_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = 1000,
   parameter int unsigned HR_W       = 5,
   parameter int unsigned HR_MAX     = 23
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   countdown_timer_core_if.slave  bus
);

   localparam logic [HR_W-1:0] HR_MAX_V = HR_W'(HR_MAX);

   logic [STATE_W-1:0] state_q, state_d;
   logic [FIELD_W-1:0] field_q, field_d;
   logic [MS_W-1:0]    ms_q, ms_d;
   logic [SEC_W-1:0]   sec_q, sec_d;
   logic [MIN_W-1:0]   min_q, min_d;
   logic [HR_W-1:0]    hr_q, hr_d;
   logic [SEC_W-1:0]   pre_sec_q, pre_sec_d;
   logic [MIN_W-1:0]   pre_min_q, pre_min_d;
   logic [HR_W-1:0]    pre_hr_q, pre_hr_d;
   logic               done_q, done_d;
   logic               alarm_q, alarm_d;

   logic               tick;
   logic               rlud;
   logic               time_nz;
   logic               last_ms;
   logic               presc_en;
   logic               presc_clr;
   logic [MS_W-1:0]    ms_dec;
   logic [SEC_W-1:0]   sec_dec;
   logic [MIN_W-1:0]   min_dec;
   logic [HR_W-1:0]    hr_dec;

   assign rlud     = bus.i_up | bus.i_down | bus.i_left | bus.i_right;
   assign time_nz  = (hr_q != '0) || (min_q != '0) || (sec_q != '0);
   assign last_ms  = !time_nz && (ms_q == MS_W'(1));
   assign presc_en = (state_q == ST_RUN);
   // i_set from any state other than SET always lands in SET
   assign presc_clr = bus.i_set && (state_q != ST_SET);

   ms_tick_gen #(
      .CLK_PER_MS (CLK_PER_MS)
   ) u_tick (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_en   (presc_en),
      .i_clr  (presc_clr),
      .o_tick (tick)
   );

   // One-ms decrement with borrow chain ms->sec->min->hr
   always_comb begin
      ms_dec  = ms_q - MS_W'(1);
      sec_dec = sec_q;
      min_dec = min_q;
      hr_dec  = hr_q;
      if (ms_q == '0) begin
         ms_dec  = MS_MAX;
         sec_dec = sec_q - SEC_W'(1);
         if (sec_q == '0) begin
            sec_dec = SEC_MAX;
            min_dec = min_q - MIN_W'(1);
            if (min_q == '0) begin
               min_dec = MIN_MAX;
               hr_dec  = hr_q - HR_W'(1);
            end
         end
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      ms_d      = ms_q;
      sec_d     = sec_q;
      min_d     = min_q;
      hr_d      = hr_q;
      pre_sec_d = pre_sec_q;
      pre_min_d = pre_min_q;
      pre_hr_d  = pre_hr_q;
      done_d    = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (bus.i_set) begin
               state_d = ST_SET;
               field_d = FLD_SEC;
               ms_d    = '0;
            end
         end

         ST_SET: begin
            if (bus.i_set) begin
               pre_sec_d = sec_q;
               pre_min_d = min_q;
               pre_hr_d  = hr_q;
               state_d   = time_nz ? ST_PAUSE : ST_INIT;
            end else begin
               // Edit applies to the field selected before any move this cycle
               if (bus.i_up ^ bus.i_down) begin
                  case (field_q)
                     FLD_SEC: sec_d = wrap_step6(sec_q, SEC_MAX, bus.i_up);
                     FLD_MIN: min_d = wrap_step6(min_q, MIN_MAX, bus.i_up);
                     FLD_HR: begin
                        if (bus.i_up) hr_d = (hr_q >= HR_MAX_V) ? '0 : hr_q + HR_W'(1);
                        else          hr_d = (hr_q == '0) ? HR_MAX_V : hr_q - HR_W'(1);
                     end
                     default: ;
                  endcase
               end
               if (bus.i_left ^ bus.i_right) begin
                  field_d = field_step(field_q, bus.i_right);
               end
            end
         end

         ST_PAUSE: begin
            if (bus.i_set) begin
               state_d = ST_SET;
               field_d = FLD_SEC;
               ms_d    = '0;
            end else if (rlud) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (bus.i_set) begin
               state_d = ST_SET;
               field_d = FLD_SEC;
               ms_d    = '0;
            end else begin
               if (tick) begin
                  if (last_ms) begin
                     done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                     ms_d  = '0;
                     sec_d = pre_sec_q;
                     min_d = pre_min_q;
                     hr_d  = pre_hr_q;
                     if ((pre_sec_q == '0) && (pre_min_q == '0) && (pre_hr_q == '0)) begin
                        state_d = ST_FINISH;
                     end
`else
                     ms_d    = '0;
                     sec_d   = '0;
                     min_d   = '0;
                     hr_d    = '0;
                     state_d = ST_FINISH;
`endif
                  end else begin
                     ms_d  = ms_dec;
                     sec_d = sec_dec;
                     min_d = min_dec;
                     hr_d  = hr_dec;
                  end
               end
               // Pause wins over staying in RUN, but expiry wins over pause
               if (rlud && (state_d == ST_RUN)) begin
                  state_d = ST_PAUSE;
               end
            end
         end

         ST_FINISH: begin
            if (bus.i_set) begin
               state_d = ST_SET;
               field_d = FLD_SEC;
               ms_d    = '0;
               sec_d   = '0;
               min_d   = '0;
               hr_d    = '0;
            end else if (rlud) begin
               state_d = ST_INIT;
               ms_d    = '0;
               sec_d   = pre_sec_q;
               min_d   = pre_min_q;
               hr_d    = pre_hr_q;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Alarm level follows FINISH (never raised in auto-reload builds)
   always_comb begin
      alarm_d = 1'b0;
`ifndef TIMER_AUTORELOAD_EN
      alarm_d = (state_d == ST_FINISH);
`endif
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= ST_INIT;
         field_q   <= FLD_SEC;
         ms_q      <= '0;
         sec_q     <= '0;
         min_q     <= '0;
         hr_q      <= '0;
         pre_sec_q <= '0;
         pre_min_q <= '0;
         pre_hr_q  <= '0;
         done_q    <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         ms_q      <= ms_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hr_q      <= hr_d;
         pre_sec_q <= pre_sec_d;
         pre_min_q <= pre_min_d;
         pre_hr_q  <= pre_hr_d;
         done_q    <= done_d;
         alarm_q   <= alarm_d;
      end
   end

   assign bus.o_ms    = ms_q;
   assign bus.o_sec   = sec_q;
   assign bus.o_min   = min_q;
   assign bus.o_hr    = hr_q;
   assign bus.o_state = state_q;
   assign bus.o_field = field_q;
   assign bus.o_done  = done_q;
   assign bus.o_alarm = alarm_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Testbench for countdown_timer_core (CLK_PER_MS=4, HR_W=5, HR_MAX=23).
// Vectors: {idle cycles before, buttons, expected outputs after the edge}.
module tb_countdown_timer_core;

   localparam int unsigned CLK_PER_MS = 4;
   localparam int unsigned HR_W       = 5;
   localparam int unsigned HR_MAX     = 23;

   // State codes as seen on o_state
   localparam int SI = 0;
   localparam int SF = 1;
   localparam int SP = 2;
   localparam int SR = 3;
   localparam int SS = 4;

   // Buttons {set, up, down, left, right}
   localparam logic [4:0] B_NO = 5'b00000;
   localparam logic [4:0] B_ST = 5'b10000;
   localparam logic [4:0] B_UP = 5'b01000;
   localparam logic [4:0] B_DN = 5'b00100;
   localparam logic [4:0] B_LT = 5'b00010;
   localparam logic [4:0] B_RT = 5'b00001;

   typedef struct {
      int         pre;
      logic [4:0] btn;
      int         ms;
      int         sec;
      int         min;
      int         hr;
      int         st;
      int         fld;
      int         done;
      int         alarm;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs_a[$];
   vec_t vecs_b[$];
   vec_t sb[$];

   countdown_timer_core_if #(.HR_W(HR_W)) bus ();

   countdown_timer_core #(
      .CLK_PER_MS (CLK_PER_MS),
      .HR_W       (HR_W),
      .HR_MAX     (HR_MAX)
   ) dut (
      .i_clk  (clk),
      .i_rstn (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int pre, input logic [4:0] btn, input int ms, input int sec,
                               input int min, input int hr, input int st, input int fld,
                               input int done, input int alarm);
      vec_t v;
      v.pre = pre; v.btn = btn; v.ms = ms; v.sec = sec; v.min = min; v.hr = hr;
      v.st = st; v.fld = fld; v.done = done; v.alarm = alarm;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Pop the oldest expectation and compare it with the current outputs
   task automatic check_out(input string tag);
      vec_t e;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".ms"},    int'(bus.o_ms),    e.ms);
      chk({tag, ".sec"},   int'(bus.o_sec),   e.sec);
      chk({tag, ".min"},   int'(bus.o_min),   e.min);
      chk({tag, ".hr"},    int'(bus.o_hr),    e.hr);
      chk({tag, ".state"}, int'(bus.o_state), e.st);
      chk({tag, ".field"}, int'(bus.o_field), e.fld);
      chk({tag, ".done"},  int'(bus.o_done),  e.done);
      chk({tag, ".alarm"}, int'(bus.o_alarm), e.alarm);
   endtask

   task automatic set_btn(input logic [4:0] b);
      bus.i_set   = b[4];
      bus.i_up    = b[3];
      bus.i_down  = b[2];
      bus.i_left  = b[1];
      bus.i_right = b[0];
   endtask

   // Idle v.pre cycles, pulse v.btn for one cycle, check just after the edge
   task automatic apply(input vec_t v, input string tag);
      repeat (v.pre) @(negedge clk);
      @(negedge clk);
      set_btn(v.btn);
      sb.push_back(v);
      @(posedge clk);
      #1;
      set_btn(B_NO);
      check_out(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.push_back(mk(0, B_NO, 0, 0, 0, 0, SI, 0, 0, 0));
      check_out(tag);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      set_btn(B_NO);

      // Set sec=2 min=1, run, pause/resume, then SET-mode editing corners
      //               pre btn          ms   sec min hr  st  fld d  a
      vecs_a.push_back(mk(0,  B_NO,      0,   0,  0,  0, SI, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   0,  0,  0, SI, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_ST,      0,   0,  0,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   1,  0,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   2,  0,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_RT,      0,   2,  0,  0, SS, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   2,  1,  0, SS, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_ST,      0,   2,  1,  0, SP, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_NO,      0,   2,  1,  0, SP, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   2,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(2,  B_NO,      0,   2,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_NO,    999,   1,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(3,  B_NO,    998,   1,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_LT,    998,   1,  1,  0, SP, 1, 0, 0));
      vecs_a.push_back(mk(19, B_NO,    998,   1,  1,  0, SP, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_RT,    998,   1,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_NO,    998,   1,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_NO,    998,   1,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_NO,    997,   1,  1,  0, SR, 1, 0, 0));
      vecs_a.push_back(mk(3,  B_DN,    996,   1,  1,  0, SP, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_ST,      0,   1,  1,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_DN,      0,   0,  1,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_DN,      0,  59,  1,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   0,  1,  0, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_UP|B_RT, 0,   1,  1,  0, SS, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_LT|B_RT, 0,   1,  1,  0, SS, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_UP|B_DN|B_RT, 0, 1, 1, 0, SS, 2, 0, 0));
      vecs_a.push_back(mk(0,  B_DN,      0,   1,  1, 23, SS, 2, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   1,  1,  0, SS, 2, 0, 0));
      vecs_a.push_back(mk(0,  B_DN,      0,   1,  1, 23, SS, 2, 0, 0));
      vecs_a.push_back(mk(0,  B_RT,      0,   1,  1, 23, SS, 0, 0, 0));
      vecs_a.push_back(mk(0,  B_LT,      0,   1,  1, 23, SS, 2, 0, 0));
      vecs_a.push_back(mk(0,  B_LT,      0,   1,  1, 23, SS, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_UP,      0,   1,  2, 23, SS, 1, 0, 0));
      vecs_a.push_back(mk(0,  B_ST,      0,   1,  2, 23, SP, 1, 0, 0));

      // After reset: zero commit, 1 s preset, run up to one ms before expiry
      vecs_b.push_back(mk(0,  B_ST,      0,   0,  0,  0, SS, 0, 0, 0));
      vecs_b.push_back(mk(0,  B_ST,      0,   0,  0,  0, SI, 0, 0, 0));
      vecs_b.push_back(mk(0,  B_ST,      0,   0,  0,  0, SS, 0, 0, 0));
      vecs_b.push_back(mk(0,  B_UP,      0,   1,  0,  0, SS, 0, 0, 0));
      vecs_b.push_back(mk(0,  B_ST,      0,   1,  0,  0, SP, 0, 0, 0));
      vecs_b.push_back(mk(0,  B_UP,      0,   1,  0,  0, SR, 0, 0, 0));
      vecs_b.push_back(mk(3998, B_NO,    1,   0,  0,  0, SR, 0, 0, 0));

      do_reset("rst_hold");
      foreach (vecs_a[i]) apply(vecs_a[i], $sformatf("A%0d", i));

      do_reset("rst_again");
      foreach (vecs_b[i]) apply(vecs_b[i], $sformatf("B%0d", i));

      // Expiry of the 1 s preset
`ifdef TIMER_AUTORELOAD_EN
      apply(mk(0, B_NO,      0, 1, 0, 0, SR, 0, 1, 0), "reload_done");
      apply(mk(0, B_NO,      0, 1, 0, 0, SR, 0, 0, 0), "reload_after");
`else
      apply(mk(0, B_NO,      0, 0, 0, 0, SF, 0, 1, 1), "finish_done");
      apply(mk(0, B_NO,      0, 0, 0, 0, SF, 0, 0, 1), "finish_hold");
      apply(mk(0, B_UP,      0, 1, 0, 0, SI, 0, 0, 0), "finish_reload");
`endif
      // set has priority over up
      apply(mk(0, B_ST|B_UP, 0, 1, 0, 0, SS, 0, 0, 0), "set_prio");

      // hr borrow through min and sec, then set from RUN keeps counters
      apply(mk(0, B_DN,      0,  0,  0, 0, SS, 0, 0, 0), "D_sec0");
      apply(mk(0, B_LT,      0,  0,  0, 0, SS, 2, 0, 0), "D_fld_hr");
      apply(mk(0, B_UP,      0,  0,  0, 1, SS, 2, 0, 0), "D_hr1");
      apply(mk(0, B_ST,      0,  0,  0, 1, SP, 2, 0, 0), "D_commit");
      apply(mk(0, B_RT,      0,  0,  0, 1, SR, 2, 0, 0), "D_run");
      apply(mk(3, B_NO,    999, 59, 59, 0, SR, 2, 0, 0), "D_borrow");
      apply(mk(0, B_ST,      0, 59, 59, 0, SS, 0, 0, 0), "D_set_run");

      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
